// File: rtl/montmult_iter_if.sv
// Operand/result bundle for the iterative Montgomery multiplier.
interface montmult_iter_if #(
    parameter int WIDTH = 1024,
    parameter int WORD  = 64
);
    // start is a request sampled only while the engine is idle; it is not
    // held until acknowledged. busy is high while an operation is in flight,
    // and done pulses for one cycle when result becomes valid.
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic [WORD-1:0]  n0_prime;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             done;

    modport master (
        output start, a, b, n, n0_prime,
        input  busy, result, done
    );

    modport slave (
        input  start, a, b, n, n0_prime,
        output busy, result, done
    );
endinterface

// File: rtl/montmult_iter.sv
// Digit-serial Montgomery multiplier: result = a*b*2^-WIDTH mod n, one WORD digit per cycle.
// Optional macro MONTMULT_ITER_FINAL_SUB_EN adds the final conditional subtraction so result < n.
module montmult_iter #(
    parameter int WIDTH = 1024,
    parameter int WORD  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    montmult_iter_if.slave       bus,
    output logic [1:0]           dbg_state,
    output logic                 dbg_ovf
);
    localparam int D  = WIDTH / WORD;
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam int SW = WIDTH + WORD + 2;
    localparam logic [CW-1:0] LAST = CW'(D - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOP   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             iterate;
    logic             finish;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [WORD-1:0]  n0_q;
    logic [WIDTH:0]   t_q;
    logic [CW-1:0]    i_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    logic [WORD-1:0]       a_i;
    logic [WIDTH+WORD-1:0] ab;
    logic [WORD-1:0]       lo;
    logic [WORD-1:0]       q;
    logic [WIDTH+WORD-1:0] qn;
    logic [SW-1:0]         sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        iterate    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = LOOP;
                end
            end
            LOOP: begin
                iterate = 1'b1;
                if (i_q == LAST) state_next = FINISH;
            end
            FINISH: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // a is consumed low digit first by shifting the latched copy right each iteration.
    assign a_i = a_q[WORD-1:0];
    assign ab  = {{WIDTH{1'b0}}, a_i} * {{WORD{1'b0}}, b_q};
    assign lo  = t_q[WORD-1:0] + ab[WORD-1:0];
    assign q   = lo * n0_q;
    assign qn  = {{WIDTH{1'b0}}, q} * {{WORD{1'b0}}, n_q};
    assign sum = {{(WORD + 1){1'b0}}, t_q} + {2'b00, ab} + {2'b00, qn};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            n0_q     <= '0;
            t_q      <= '0;
            i_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= finish;
            if (accept) begin
                a_q    <= bus.a;
                b_q    <= bus.b;
                n_q    <= bus.n;
                n0_q   <= bus.n0_prime;
                t_q    <= '0;
                i_q    <= '0;
                busy_q <= 1'b1;
            end
            if (iterate) begin
                a_q <= a_q >> WORD;
                // Low WORD bits of sum are zero by choice of q, so the shift is exact.
                t_q <= sum[WIDTH+WORD:WORD];
                i_q <= i_q + CW'(1);
            end
            if (finish) begin
                busy_q <= 1'b0;
`ifdef MONTMULT_ITER_FINAL_SUB_EN
                if (t_q >= {1'b0, n_q}) result_q <= WIDTH'(t_q - {1'b0, n_q});
                else                    result_q <= t_q[WIDTH-1:0];
`else
                result_q <= t_q[WIDTH-1:0];
`endif
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign dbg_state  = state;
    // Sum MSB is headroom only; it should never be set for operands below n.
    assign dbg_ovf    = iterate & sum[SW-1];
endmodule
